// File: rtl/vga_text_buf_arbiter.sv
// Single-port text RAM arbiter: VGA scan-out reads, a screen-clear sweep and
// buffered CPU writes share one RAM port under fixed priority.
module vga_text_buf_arbiter #(
    parameter int COLS       = 80,
    parameter int ROWS       = 30,
    parameter int ADDR_W     = 12,
    parameter int CHAR_W     = 8,
    parameter int COLOR_W    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_cpu_wr_en,
    input  logic [ADDR_W-1:0]  i_cpu_addr,
    input  logic [CHAR_W-1:0]  i_cpu_char,
    input  logic [COLOR_W-1:0] i_cpu_color,
    output logic               o_cpu_ready,
    output logic               o_cpu_drop,
    input  logic               i_clr_start,
    input  logic [CHAR_W-1:0]  i_clr_char,
    input  logic [COLOR_W-1:0] i_clr_color,
    output logic               o_clr_busy,
    input  logic               i_vga_rd_req,
    input  logic [ADDR_W-1:0]  i_vga_addr,
    output logic [CHAR_W-1:0]  o_vga_char,
    output logic [COLOR_W-1:0] o_vga_color,
    output logic               o_vga_rd_valid,
    output logic               o_ram_en,
    output logic               o_ram_we,
    output logic [ADDR_W-1:0]  o_ram_addr,
    output logic [CHAR_W-1:0]  o_ram_wchar,
    output logic [COLOR_W-1:0] o_ram_wcolor,
    input  logic [CHAR_W-1:0]  i_ram_rchar,
    input  logic [COLOR_W-1:0] i_ram_rcolor
);
    // state   | meaning
    // S_IDLE  | no sweep; FIFO writes may use the RAM
    // S_CLEAR | sweeping fill value over every cell, FIFO held
    localparam int                CELLS     = COLS * ROWS;
    localparam int                PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

    typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

    logic [ADDR_W-1:0]  r_fifo_addr  [FIFO_DEPTH];
    logic [CHAR_W-1:0]  r_fifo_char  [FIFO_DEPTH];
    logic [COLOR_W-1:0] r_fifo_color [FIFO_DEPTH];
    logic [PTR_W:0]     r_wr_ptr;
    logic [PTR_W:0]     r_rd_ptr;

    state_t             r_state;
    logic               r_clr_busy;
    logic [ADDR_W-1:0]  r_clr_ptr;
    logic [CHAR_W-1:0]  r_clr_char;
    logic [COLOR_W-1:0] r_clr_color;

    logic               r_cpu_drop;
    logic               r_ram_en;
    logic               r_ram_we;
    logic [ADDR_W-1:0]  r_ram_addr;
    logic [CHAR_W-1:0]  r_ram_wchar;
    logic [COLOR_W-1:0] r_ram_wcolor;
    logic               r_rd_pend;
    logic               r_vga_valid;
    logic [CHAR_W-1:0]  r_vga_char;
    logic [COLOR_W-1:0] r_vga_color;

    logic               w_full;
    logic               w_empty;
    logic               w_accept;
    logic               w_in_range;
    logic               w_push;
    logic               w_gnt_clr;
    logic               w_gnt_fifo;
    logic [PTR_W-1:0]   w_wr_idx;
    logic [PTR_W-1:0]   w_rd_idx;

    assign w_wr_idx   = r_wr_ptr[PTR_W-1:0];
    assign w_rd_idx   = r_rd_ptr[PTR_W-1:0];
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) && (w_wr_idx == w_rd_idx);
    assign w_accept   = i_cpu_wr_en && !w_full;
    assign w_in_range = ({1'b0, i_cpu_addr} < (ADDR_W + 1)'(CELLS));
    assign w_push     = w_accept && w_in_range;
    assign w_gnt_clr  = !i_vga_rd_req && (r_state == S_CLEAR);
    assign w_gnt_fifo = !i_vga_rd_req && !r_clr_busy && !w_empty;

    assign o_cpu_ready    = !w_full;
    assign o_cpu_drop     = r_cpu_drop;
    assign o_clr_busy     = r_clr_busy;
    assign o_ram_en       = r_ram_en;
    assign o_ram_we       = r_ram_we;
    assign o_ram_addr     = r_ram_addr;
    assign o_ram_wchar    = r_ram_wchar;
    assign o_ram_wcolor   = r_ram_wcolor;
    assign o_vga_rd_valid = r_vga_valid;
    // Read data passes straight through while valid, otherwise the last result is held
    assign o_vga_char     = r_vga_valid ? i_ram_rchar  : r_vga_char;
    assign o_vga_color    = r_vga_valid ? i_ram_rcolor : r_vga_color;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_addr[w_wr_idx]  <= i_cpu_addr;
            r_fifo_char[w_wr_idx]  <= i_cpu_char;
            r_fifo_color[w_wr_idx] <= i_cpu_color;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_state      <= S_IDLE;
            r_clr_busy   <= 1'b0;
            r_clr_ptr    <= '0;
            r_clr_char   <= '0;
            r_clr_color  <= '0;
            r_cpu_drop   <= 1'b0;
            r_ram_en     <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wchar  <= '0;
            r_ram_wcolor <= '0;
            r_rd_pend    <= 1'b0;
            r_vga_valid  <= 1'b0;
            r_vga_char   <= '0;
            r_vga_color  <= '0;
        end else begin
            if (w_push)     r_wr_ptr <= r_wr_ptr + (PTR_W + 1)'(1);
            if (w_gnt_fifo) r_rd_ptr <= r_rd_ptr + (PTR_W + 1)'(1);
            r_cpu_drop <= w_accept && !w_in_range;

            if (i_vga_rd_req) begin
                r_ram_en   <= 1'b1;
                r_ram_we   <= 1'b0;
                r_ram_addr <= i_vga_addr;
            end else if (w_gnt_clr) begin
                r_ram_en     <= 1'b1;
                r_ram_we     <= 1'b1;
                r_ram_addr   <= r_clr_ptr;
                r_ram_wchar  <= r_clr_char;
                r_ram_wcolor <= r_clr_color;
            end else if (w_gnt_fifo) begin
                r_ram_en     <= 1'b1;
                r_ram_we     <= 1'b1;
                r_ram_addr   <= r_fifo_addr[w_rd_idx];
                r_ram_wchar  <= r_fifo_char[w_rd_idx];
                r_ram_wcolor <= r_fifo_color[w_rd_idx];
            end else begin
                r_ram_en <= 1'b0;
                r_ram_we <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_clr_start) begin
                        r_state     <= S_CLEAR;
                        r_clr_busy  <= 1'b1;
                        r_clr_ptr   <= '0;
                        r_clr_char  <= i_clr_char;
                        r_clr_color <= i_clr_color;
                    end
                end
                S_CLEAR: begin
                    // The pointer only moves when the sweep actually owned the RAM
                    if (w_gnt_clr) begin
                        if (r_clr_ptr == LAST_CELL) begin
                            r_state    <= S_IDLE;
                            r_clr_busy <= 1'b0;
                        end else begin
                            r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_clr_busy <= 1'b0;
                end
            endcase

            r_rd_pend   <= i_vga_rd_req;
            r_vga_valid <= r_rd_pend;
            if (r_vga_valid) begin
                r_vga_char  <= i_ram_rchar;
                r_vga_color <= i_ram_rcolor;
            end
        end
    end
endmodule

// File: tb/tb_vga_text_buf_arbiter.sv
// Bench for vga_text_buf_arbiter: RAM fixture, queue-based reference model
// compared every cycle, directed scenarios with literal expectations, random traffic.
module tb_vga_text_buf_arbiter;
    localparam int CELLS = 2400;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_wr_en;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_char, cpu_color;
    logic        cpu_ready, cpu_drop;
    logic        clr_start;
    logic [7:0]  clr_char, clr_color;
    logic        clr_busy;
    logic        vga_rd_req;
    logic [11:0] vga_addr;
    logic [7:0]  vga_char, vga_color;
    logic        vga_rd_valid;
    logic        ram_en, ram_we;
    logic [11:0] ram_addr;
    logic [7:0]  ram_wchar, ram_wcolor;
    logic [7:0]  ram_rchar, ram_rcolor;

    always #5 clk = ~clk;

    vga_text_buf_arbiter dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cpu_wr_en(cpu_wr_en), .i_cpu_addr(cpu_addr), .i_cpu_char(cpu_char),
        .i_cpu_color(cpu_color), .o_cpu_ready(cpu_ready), .o_cpu_drop(cpu_drop),
        .i_clr_start(clr_start), .i_clr_char(clr_char), .i_clr_color(clr_color),
        .o_clr_busy(clr_busy),
        .i_vga_rd_req(vga_rd_req), .i_vga_addr(vga_addr), .o_vga_char(vga_char),
        .o_vga_color(vga_color), .o_vga_rd_valid(vga_rd_valid),
        .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
        .o_ram_wchar(ram_wchar), .o_ram_wcolor(ram_wcolor),
        .i_ram_rchar(ram_rchar), .i_ram_rcolor(ram_rcolor)
    );

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pat_c(input int i);
        return 8'(i * 7 + 3);
    endfunction
    function automatic logic [7:0] pat_o(input int i);
        return 8'(i) ^ 8'h5A;
    endfunction

    // Single-port RAM fixture with 1-cycle read latency
    logic [7:0] ram_ch [4096];
    logic [7:0] ram_co [4096];
    always @(posedge clk) begin
        if (ram_en === 1'b1) begin
            if (ram_we === 1'b1) begin
                ram_ch[ram_addr] <= ram_wchar;
                ram_co[ram_addr] <= ram_wcolor;
            end else begin
                ram_rchar  <= ram_ch[ram_addr];
                ram_rcolor <= ram_co[ram_addr];
            end
        end
    end

    // Reference model: write queue, sweep counter, shadow memory
    typedef struct packed { logic [11:0] a; logic [7:0] c; logic [7:0] k; } wr_t;
    wr_t         q[$];
    logic [7:0]  sh_ch [4096];
    logic [7:0]  sh_co [4096];
    logic        m_clr;
    int          m_ptr;
    logic [7:0]  m_cch, m_cco;
    logic        m_en, m_we, m_drop, m_pend, m_valid;
    logic [11:0] m_addr;
    logic [7:0]  m_wch, m_wco, m_rch, m_rco, m_hch, m_hco;

    always @(posedge clk) begin : p_model
        wr_t  e;
        logic was_clr;
        logic acc;
        int   sz;
        if (m_valid === 1'b1) begin
            m_hch = m_rch;
            m_hco = m_rco;
        end
        if (m_en === 1'b1 && m_we === 1'b1) begin
            sh_ch[m_addr] = m_wch;
            sh_co[m_addr] = m_wco;
        end else if (m_en === 1'b1) begin
            m_rch = sh_ch[m_addr];
            m_rco = sh_co[m_addr];
        end
        if (!rst_n) begin
            q.delete();
            m_clr = 1'b0; m_ptr = 0; m_cch = '0; m_cco = '0;
            m_en = 1'b0; m_we = 1'b0; m_addr = '0; m_wch = '0; m_wco = '0;
            m_drop = 1'b0; m_pend = 1'b0; m_valid = 1'b0; m_hch = '0; m_hco = '0;
        end else begin
            sz      = q.size();
            was_clr = m_clr;
            acc     = cpu_wr_en && (sz < 4);
            m_valid = m_pend;
            m_pend  = vga_rd_req;
            if (vga_rd_req) begin
                m_en = 1'b1; m_we = 1'b0; m_addr = vga_addr;
            end else if (was_clr) begin
                m_en = 1'b1; m_we = 1'b1; m_addr = 12'(m_ptr);
                m_wch = m_cch; m_wco = m_cco;
                m_ptr++;
                if (m_ptr == CELLS) m_clr = 1'b0;
            end else if (sz > 0) begin
                e = q.pop_front();
                m_en = 1'b1; m_we = 1'b1; m_addr = e.a; m_wch = e.c; m_wco = e.k;
            end else begin
                m_en = 1'b0; m_we = 1'b0;
            end
            m_drop = acc && (int'(cpu_addr) >= CELLS);
            if (acc && int'(cpu_addr) < CELLS) q.push_back('{a: cpu_addr, c: cpu_char, k: cpu_color});
            if (clr_start && !was_clr) begin
                m_clr = 1'b1; m_ptr = 0; m_cch = clr_char; m_cco = clr_color;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_cpu_ready", cpu_ready, q.size() < 4);
            chk("m_cpu_drop", cpu_drop, m_drop);
            chk("m_clr_busy", clr_busy, m_clr);
            chk("m_ram_en", ram_en, m_en);
            chk("m_ram_we", ram_we, m_we);
            if (m_en) chk("m_ram_addr", ram_addr, m_addr);
            if (m_en && m_we) begin
                chk("m_ram_wchar", ram_wchar, m_wch);
                chk("m_ram_wcolor", ram_wcolor, m_wco);
            end
            chk("m_vga_valid", vga_rd_valid, m_valid);
            chk("m_vga_char", vga_char, m_valid ? m_rch : m_hch);
            chk("m_vga_color", vga_color, m_valid ? m_rco : m_hco);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int acc, bad, cnt, to;
        bit found;
        for (int i = 0; i < 4096; i++) begin
            ram_ch[i] = pat_c(i); ram_co[i] = pat_o(i);
            sh_ch[i]  = pat_c(i); sh_co[i]  = pat_o(i);
        end
        ram_rchar = '0; ram_rcolor = '0; m_rch = '0; m_rco = '0;
        rst_n = 1'b0; cpu_wr_en = 1'b0; cpu_addr = '0; cpu_char = '0; cpu_color = '0;
        clr_start = 1'b0; clr_char = '0; clr_color = '0; vga_rd_req = 1'b0; vga_addr = '0;

        step(); chk_en = 1'b1; step(); step();
        chk("rst_ready", cpu_ready, 1);
        chk("rst_drop", cpu_drop, 0);
        chk("rst_busy", clr_busy, 0);
        chk("rst_valid", vga_rd_valid, 0);
        chk("rst_vga_char", vga_char, 0);
        chk("rst_vga_color", vga_color, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", {ram_wchar, ram_wcolor}, 0);
        rst_n = 1'b1; step();

        // Single write then read-back
        cpu_wr_en = 1'b1; cpu_addr = 12'd5; cpu_char = 8'h41; cpu_color = 8'h0F;
        step(); cpu_wr_en = 1'b0; step();
        chk("t1_we", ram_we, 1);
        chk("t1_addr", ram_addr, 5);
        chk("t1_wdata", {ram_wchar, ram_wcolor}, 16'h410F);
        step();
        chk("t1_cell5", {ram_ch[5], ram_co[5]}, 16'h410F);
        vga_rd_req = 1'b1; vga_addr = 12'd5; step(); vga_rd_req = 1'b0;
        chk("t1_rd_en", {ram_en, ram_we}, 2'b10);
        step();
        chk("t1_rd_valid", vga_rd_valid, 1);
        chk("t1_rd_data", {vga_char, vga_color}, 16'h410F);
        step();
        chk("t1_valid_drop", vga_rd_valid, 0);
        chk("t1_hold", {vga_char, vga_color}, 16'h410F);

        // VGA holds the port; FIFO fills then drains in order
        vga_rd_req = 1'b1; vga_addr = 12'd7; acc = 0;
        for (int i = 0; i < 5; i++) begin
            cpu_wr_en = 1'b1; cpu_addr = 12'(10 + i); cpu_char = 8'(8'h60 + i); cpu_color = 8'(i);
            if (cpu_ready) acc++;
            step();
        end
        cpu_wr_en = 1'b0;
        chk("t2_accepts", acc, 4);
        chk("t2_ready_low", cpu_ready, 0);
        for (int i = 0; i < 3; i++) begin
            chk("t2_no_write", ram_we, 0);
            step();
        end
        vga_rd_req = 1'b0; step();
        for (int i = 0; i < 4; i++) begin
            chk("t2_drain_we", ram_we, 1);
            chk("t2_drain_addr", ram_addr, 10 + i);
            chk("t2_drain_char", ram_wchar, 8'h60 + i);
            step();
        end
        chk("t2_idle", ram_en, 0);
        chk("t2_cell14_untouched", ram_ch[14], pat_c(14));

        // Full clear with a CPU write and an ignored restart mid-sweep
        clr_char = 8'h20; clr_color = 8'h07; clr_start = 1'b1; step();
        clr_start = 1'b0; clr_char = 8'hFF; clr_color = 8'hFF;
        cnt = 0;
        while (clr_busy && cnt < 3000) begin
            cnt++;
            cpu_wr_en = (cnt == 10);
            cpu_addr = 12'd0; cpu_char = 8'h58; cpu_color = 8'h1E;
            clr_start = (cnt == 20);
            step();
        end
        cpu_wr_en = 1'b0; clr_start = 1'b0;
        chk("t3_busy_cycles", cnt, 2400);
        repeat (4) step();
        bad = 0;
        for (int c = 1; c < CELLS; c++) if (ram_ch[c] != 8'h20 || ram_co[c] != 8'h07) bad++;
        chk("t3_fill_bad_cells", bad, 0);
        chk("t4_cell0", {ram_ch[0], ram_co[0]}, 16'h581E);
        chk("t4_cell1", {ram_ch[1], ram_co[1]}, 16'h2007);
        vga_rd_req = 1'b1; vga_addr = 12'd2399; step(); vga_rd_req = 1'b0; step();
        chk("t3_rd_last", {vga_rd_valid, vga_char, vga_color}, 17'h12007);

        // Out-of-range address is accepted and dropped
        cpu_wr_en = 1'b1; cpu_addr = 12'd2400; cpu_char = 8'hAA; cpu_color = 8'hBB;
        chk("t5_ready", cpu_ready, 1);
        step(); cpu_wr_en = 1'b0;
        chk("t5_drop_pulse", cpu_drop, 1);
        step();
        chk("t5_drop_end", cpu_drop, 0);
        chk("t5_no_write", ram_en, 0);
        step();
        chk("t5_no_write2", ram_en, 0);
        chk("t5_cell2400", ram_ch[2400], pat_c(2400));

        // Reset while the sweep drives cell 99
        clr_char = 8'h33; clr_color = 8'h44; clr_start = 1'b1; step(); clr_start = 1'b0;
        cpu_wr_en = 1'b1; cpu_addr = 12'd3; cpu_char = 8'h77; cpu_color = 8'h66; step();
        cpu_wr_en = 1'b0;
        found = 1'b0; to = 0;
        while (!found && to < 500) begin
            if (ram_we === 1'b1 && ram_addr == 12'd99) found = 1'b1;
            else begin step(); to++; end
        end
        chk("t6_reach_cell99", found, 1);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("t6_busy", clr_busy, 0);
        chk("t6_ram_en", ram_en, 0);
        chk("t6_ready", cpu_ready, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t6_fifo_empty", ram_en, 0);
        end
        bad = 0;
        for (int c = 0; c < 100; c++) if (ram_ch[c] != 8'h33 || ram_co[c] != 8'h44) bad++;
        for (int c = 100; c < CELLS; c++) if (ram_ch[c] != 8'h20 || ram_co[c] != 8'h07) bad++;
        chk("t6_partial_fill", bad, 0);

        // Random traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            vga_rd_req = ($urandom_range(0, 99) < 35);
            vga_addr   = 12'($urandom_range(0, CELLS - 1));
            cpu_wr_en  = 1'($urandom_range(0, 1));
            cpu_addr   = 12'($urandom_range(0, CELLS + 99));
            cpu_char   = 8'($urandom);
            cpu_color  = 8'($urandom);
            clr_start  = (cyc == 300) || ($urandom_range(0, 1999) == 0);
            clr_char   = 8'($urandom);
            clr_color  = 8'($urandom);
            step();
        end
        vga_rd_req = 1'b0; cpu_wr_en = 1'b0; clr_start = 1'b0;
        to = 0;
        while (clr_busy && to < 6000) begin step(); to++; end
        chk("rnd_clear_done", clr_busy, 0);
        repeat (10) step();
        bad = 0;
        for (int c = 0; c < 4096; c++) if (ram_ch[c] !== sh_ch[c] || ram_co[c] !== sh_co[c]) bad++;
        chk("rnd_final_ram", bad, 0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/vga_text_buf_arbiter.md
Name: vga_text_buf_arbiter

Overview:
- Owns the single-port character/color RAM that backs the VGA text display.
- Arbitrates that RAM between three users: VGA scan-out reads, a hardware screen-clear engine, and CPU MMIO writes buffered in a small FIFO.
- Sits between the MMIO bus decode and the VGA module's vga_addr/ch/color inputs. The VGA module therefore sees a plain 1-cycle-latency read port, regardless of CPU traffic.

Parameters:
- COLS, 80, text columns
- ROWS, 30, text rows
- ADDR_W, 12, cell address width; must satisfy 2^ADDR_W >= COLS*ROWS
- CHAR_W, 8, character code width
- COLOR_W, 8, per-cell color attribute width
- FIFO_DEPTH, 4, CPU write FIFO entries (power of two)

Ports:
- clk  in  1  system clock (VGA pixel clock domain)
- rst_n  in  1  synchronous active-low reset
- cpu_wr_en  in  1  CPU write strobe, sampled when cpu_ready=1
- cpu_addr  in  ADDR_W  target cell index
- cpu_char  in  CHAR_W  character to write
- cpu_color  in  COLOR_W  color to write
- cpu_ready  out  1  FIFO not full
- cpu_drop  out  1  one-cycle pulse: accepted write had out-of-range address and was discarded
- clr_start  in  1  start full-screen clear (single-cycle pulse)
- clr_char  in  CHAR_W  fill character, latched at start
- clr_color  in  COLOR_W  fill color, latched at start
- clr_busy  out  1  clear sweep in progress
- vga_rd_req  in  1  VGA read request
- vga_addr  in  ADDR_W  VGA cell index
- vga_char  out  CHAR_W  read data, character
- vga_color  out  COLOR_W  read data, color
- vga_rd_valid  out  1  read data valid
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wchar  out  CHAR_W  RAM write data, character
- ram_wcolor  out  COLOR_W  RAM write data, color
- ram_rchar  in  CHAR_W  RAM read data, character (1-cycle latency)
- ram_rcolor  in  COLOR_W  RAM read data, color (1-cycle latency)

Behaviour:
- Reset (rst_n=0 at a clk edge): FIFO emptied; clear FSM goes to IDLE.
  - Reset values: cpu_ready=1, cpu_drop=0, clr_busy=0, vga_rd_valid=0, vga_char=0, vga_color=0, ram_en=0, ram_we=0, ram_addr=0, ram_wchar=0, ram_wcolor=0.
  - Reset mid-clear aborts the clear. Cells already written keep their new value.
- FIFO push:
  - cpu_wr_en & cpu_ready pushes {addr,char,color}.
  - cpu_ready = !full (combinational).
  - A pop in the same cycle does not make a full FIFO accept.
- Range check at push: cpu_addr >= COLS*ROWS is accepted (handshake completes), not stored, and cpu_drop=1 on the next cycle.
- RAM grant each cycle, fixed priority:
  1. vga_rd_req: ram_en=1, ram_we=0, ram_addr=vga_addr.
  2. Clear engine in CLEAR state: write the clear pointer.
  3. FIFO non-empty and clr_busy=0: pop head and write it.
  4. Otherwise ram_en=0.
  - RAM control outputs are registered: the grant decided in cycle N drives the RAM in cycle N+1.
- VGA read latency:
  - vga_rd_req in cycle N → RAM access in N+1 → vga_rd_valid=1 with vga_char/vga_color = RAM data in N+2.
  - Back-to-back requests give one result per cycle.
  - vga_char/vga_color hold their last value when valid=0.
- Clear FSM:
  - IDLE → CLEAR on clr_start. Latch clr_char/clr_color; pointer=0; clr_busy=1 from the next cycle.
  - In CLEAR, the pointer increments only on cycles where the clear write is granted.
  - After writing cell COLS*ROWS-1: → IDLE, clr_busy=0.
  - clr_start while in CLEAR is ignored.
- CPU writes during a clear are still accepted into the FIFO (until full) but are held until the clear finishes. They are then drained in order, so writes issued after clr_start always win over the fill.
- Same-address ordering: FIFO writes retire strictly in push order.
- A VGA read of a cell with a pending FIFO write returns the old RAM value. No bypass.
- VGA starvation of the lower-priority users is legal. Writes resume on the first cycle with no vga_rd_req.

Test Plan:
- Reset, then cpu write addr=5 char=0x41 color=0x0F with vga_rd_req=0 → RAM write at addr 5 two cycles later. Then VGA read addr 5 → vga_rd_valid with vga_char=0x41, vga_color=0x0F two cycles after the request.
- Hold vga_rd_req=1 continuously and push 5 CPU writes → cpu_ready=0 after 4 accepts, no RAM writes while requests are active. Release vga_rd_req → 4 writes retire on consecutive cycles, in order.
- clr_start with char=0x20 color=0x07 and no VGA traffic → clr_busy high for exactly 2400 cycles. Every cell reads back 0x20/0x07.
- clr_start, then cpu write addr=0 char=0x58 mid-clear → after clr_busy falls, cell 0 = 0x58 and cell 1 = 0x20.
- cpu write addr=2400 → accepted, cpu_drop pulses one cycle, no RAM write occurs.
- Assert rst_n=0 at clear cell 100 → clr_busy=0 and FIFO empty next cycle. Cells 0-99 keep the fill value; cell 100 and above are unchanged.
